blit_cmdlist_dma: RTL and testbench

BLIT_CMDLIST_DMA -- requirements
Module: blit_cmdlist_dma

---
 rtl/blit_cmdlist_dma.sv | 196 +++++++++++++++++++
 tb/tb_blit_cmdlist_dma.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_cmdlist_dma.sv
// Command-list DMA: reads a list of 32-bit blitter commands from SDRAM in bursts
// and feeds them to the blitter command FIFO through a small local buffer.
//
// state | meaning
// IDLE  | waiting for cfg_start
// REQ   | requesting the next burst once a whole burst of buffer space is free
// DATA  | collecting burst data into the buffer
// DRAIN | all words fetched, forwarding the remaining buffer contents
// ABORT | cancelled mid-burst, discarding data until the burst completes
module blit_cmdlist_dma #(
   parameter int BURST_LEN   = 16,
   parameter int BUF_DEPTH   = 32,
   parameter int SLOT_MARGIN = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cfg_start,
   input  logic [25:0] cfg_address,
   input  logic [15:0] cfg_count,
   input  logic        cfg_privaledge,
   input  logic        cfg_abort,
   output logic        busy,
   output logic        done,
   output logic        sdram_request,
   output logic [25:0] sdram_address,
   input  logic        sdram_ready,
   input  logic        sdram_rvalid,
   input  logic [31:0] sdram_rdata,
   input  logic [25:0] sdram_raddress,
   input  logic        sdram_complete,
   output logic        hwregs_blit_valid,
   output logic [31:0] hwregs_blit_command,
   output logic        hwregs_blit_privaledge,
   input  logic [9:0]  blit_fifo_slots_free
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam logic [AW:0]   BURST_OCC = (AW+1)'(BURST_LEN);
   localparam logic [AW:0]   DEPTH_OCC = (AW+1)'(BUF_DEPTH);
   localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [16:0]   BURST_CNT = 17'(BURST_LEN);
   localparam logic [9:0]    MARGIN    = 10'(SLOT_MARGIN);

   typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, ABORT} state_t;

   state_t        state_q, state_d;
   logic [25:0]   addr_q;
   logic [16:0]   count_q, issued_q, rcv_q;
   logic          priv_q;
   logic [32:0]   mem [BUF_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   occ_q, free_w;
   logic [16:0]   remain_w, burst_words;
   logic          in_count, req_ok;
   logic          start_ok, done_d, flush, wr_en, rd_en, burst_end;
   logic          done_q, valid_q, cmd_priv_q;
   logic [31:0]   cmd_q;

   // The list is consumed in arrival order; the echoed read address is informational.
   logic unused_raddress;
   assign unused_raddress = ^sdram_raddress;

   assign free_w        = DEPTH_OCC - occ_q;
   assign remain_w      = count_q - issued_q;
   assign burst_words   = (remain_w < BURST_CNT) ? remain_w : BURST_CNT;
   assign in_count      = (issued_q + rcv_q) < count_q;
   assign req_ok        = (state_q == REQ) && (free_w >= BURST_OCC) && (issued_q < count_q);
   assign sdram_request = req_ok;
   assign sdram_address = addr_q + {7'd0, issued_q, 2'b00};

   assign rd_en = (state_q != IDLE) && (occ_q != '0) && (blit_fifo_slots_free > MARGIN) && !flush;

   always_comb begin
      state_d   = state_q;
      start_ok  = 1'b0;
      done_d    = 1'b0;
      flush     = 1'b0;
      wr_en     = 1'b0;
      burst_end = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               start_ok = 1'b1;
               if (cfg_count == 16'd0) done_d = 1'b1;
               else state_d = REQ;
            end
         end
         REQ: begin
            // An accepted request must still see its burst through, even when cancelled.
            if (req_ok && sdram_ready) begin
               state_d = cfg_abort ? ABORT : DATA;
               flush   = cfg_abort;
            end else if (cfg_abort) begin
               flush   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         DATA: begin
            if (cfg_abort) begin
               flush = 1'b1;
               if (sdram_complete) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ABORT;
               end
            end else begin
               wr_en = sdram_rvalid && in_count;
               if (sdram_complete) begin
                  burst_end = 1'b1;
                  state_d   = ((issued_q + burst_words) < count_q) ? REQ : DRAIN;
               end
            end
         end
         DRAIN: begin
            if (cfg_abort) begin
               flush   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (occ_q == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         ABORT: begin
            if (sdram_complete) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         priv_q     <= 1'b0;
         issued_q   <= '0;
         rcv_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         cmd_q      <= '0;
         cmd_priv_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (start_ok) begin
            addr_q   <= {cfg_address[25:2], 2'b00};
            count_q  <= {1'b0, cfg_count};
            priv_q   <= cfg_privaledge;
            issued_q <= '0;
            rcv_q    <= '0;
         end else if (burst_end) begin
            issued_q <= issued_q + burst_words;
            rcv_q    <= '0;
         end else if ((state_q == DATA) && sdram_rvalid) begin
            rcv_q <= rcv_q + 17'd1;
         end
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
         end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({wr_en, rd_en})
               2'b10:   occ_q <= occ_q + OCC_ONE;
               2'b01:   occ_q <= occ_q - OCC_ONE;
               default: occ_q <= occ_q;
            endcase
         end
         valid_q    <= rd_en;
         cmd_q      <= rd_en ? mem[rd_ptr_q][31:0] : 32'd0;
         cmd_priv_q <= rd_en ? mem[rd_ptr_q][32] : 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr_q] <= {priv_q, sdram_rdata};
   end

   assign busy                   = (state_q != IDLE);
   assign done                   = done_q;
   assign hwregs_blit_valid      = valid_q;
   assign hwregs_blit_command    = cmd_q;
   assign hwregs_blit_privaledge = cmd_priv_q;

endmodule

// File: tb/tb_blit_cmdlist_dma.sv
// Bench for blit_cmdlist_dma: random-latency SDRAM model, list-level reference
// model feeding word/request scoreboards, and a decoupled output monitor.
module tb_blit_cmdlist_dma;

   localparam int BURST = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_start = 1'b0;
   logic [25:0] cfg_address = '0;
   logic [15:0] cfg_count = '0;
   logic        cfg_privaledge = 1'b0;
   logic        cfg_abort = 1'b0;
   logic        busy, done, sdram_request;
   logic [25:0] sdram_address;
   logic        sdram_ready, sdram_rvalid, sdram_complete;
   logic [31:0] sdram_rdata;
   logic [25:0] sdram_raddress;
   logic        hwregs_blit_valid, hwregs_blit_privaledge;
   logic [31:0] hwregs_blit_command;
   logic [9:0]  blit_fifo_slots_free = 10'd100;

   blit_cmdlist_dma dut (
      .clock(clock), .reset(reset),
      .cfg_start(cfg_start), .cfg_address(cfg_address), .cfg_count(cfg_count),
      .cfg_privaledge(cfg_privaledge), .cfg_abort(cfg_abort),
      .busy(busy), .done(done),
      .sdram_request(sdram_request), .sdram_address(sdram_address),
      .sdram_ready(sdram_ready), .sdram_rvalid(sdram_rvalid), .sdram_rdata(sdram_rdata),
      .sdram_raddress(sdram_raddress), .sdram_complete(sdram_complete),
      .hwregs_blit_valid(hwregs_blit_valid), .hwregs_blit_command(hwregs_blit_command),
      .hwregs_blit_privaledge(hwregs_blit_privaledge),
      .blit_fifo_slots_free(blit_fifo_slots_free)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];
   logic [25:0] req_q[$];
   int          fwd_seen = 0;
   int          req_acc = 0;
   int          beats_left = 0;
   bit          quiet = 0;
   bit          jitter = 0;
   logic [9:0]  slots_fixed = 10'd100;

   function automatic logic [31:0] word_of(input logic [25:0] a);
      return {a, 6'd0} ^ {6'd0, a} ^ 32'h9e37_79b9;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=present expected=absent", name);
   endtask

   // Reference: a list is count consecutive words from the aligned base, fetched
   // in bursts of BURST words starting every 4*BURST bytes, all mod 2^26.
   task automatic model_list(input logic [25:0] a, input logic [15:0] c, input logic p);
      logic [25:0] base;
      base = {a[25:2], 2'b00};
      for (int i = 0; i < int'(c); i++)
         exp_q.push_back({p, word_of(base + 26'(4 * i))});
      for (int k = 0; k < (int'(c) + BURST - 1) / BURST; k++)
         req_q.push_back(base + 26'(4 * BURST * k));
   endtask

   task automatic start_list(input logic [25:0] a, input logic [15:0] c, input logic p);
      @(negedge clock);
      model_list(a, c, p);
      cfg_address = a; cfg_count = c; cfg_privaledge = p; cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(name, 64'(done), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_request"}, 64'(sdram_request), 64'd0);
      check({tag, "_valid"}, 64'(hwregs_blit_valid), 64'd0);
      check({tag, "_command"}, 64'(hwregs_blit_command), 64'd0);
      check({tag, "_priv"}, 64'(hwregs_blit_privaledge), 64'd0);
   endtask

   initial forever begin
      @(negedge clock);
      blit_fifo_slots_free = jitter
         ? (($urandom_range(0, 3) == 0) ? 10'd2 : 10'($urandom_range(4, 50)))
         : slots_fixed;
   end

   // SDRAM model: random acceptance delay, random gaps between beats.
   initial begin
      logic [25:0] req_addr_seen, burst_addr;
      bit          ready_prev;
      ready_prev = 0; req_addr_seen = '0; burst_addr = '0;
      sdram_ready = 0; sdram_rvalid = 0; sdram_rdata = '0; sdram_raddress = '0; sdram_complete = 0;
      forever begin
         @(posedge clock);
         #1;
         sdram_rvalid = 0;
         sdram_complete = 0;
         if (reset) begin
            beats_left = 0; ready_prev = 0; sdram_ready = 0;
         end else begin
            if (ready_prev) begin
               req_acc++;
               if (req_q.size() == 0) fail_now("unexpected_request");
               else check("request_address", 64'(req_addr_seen), 64'(req_q.pop_front()));
               beats_left = BURST;
               burst_addr = req_addr_seen;
            end
            sdram_ready = 0;
            ready_prev = 0;
            if (beats_left > 0) begin
               if ($urandom_range(0, 3) != 0) begin
                  sdram_rvalid = 1;
                  sdram_rdata = word_of(burst_addr);
                  sdram_raddress = burst_addr;
                  burst_addr = burst_addr + 26'd4;
                  beats_left--;
                  sdram_complete = (beats_left == 0);
               end
            end else if (sdram_request && $urandom_range(0, 1) == 1) begin
               sdram_ready = 1;
               ready_prev = 1;
               req_addr_seen = sdram_address;
            end
         end
      end
   end

   // Output monitor: every forwarded word is popped from the scoreboard.
   initial forever begin
      @(negedge clock);
      if (!reset) begin
         if (hwregs_blit_valid) begin
            logic [32:0] e;
            fwd_seen++;
            if (quiet) fail_now("valid_while_blocked");
            else if (exp_q.size() == 0) fail_now("extra_word");
            else begin
               e = exp_q.pop_front();
               check("word", {31'd0, hwregs_blit_privaledge, hwregs_blit_command}, 64'(e));
            end
         end else begin
            check("idle_outputs_zero", {31'd0, hwregs_blit_privaledge, hwregs_blit_command}, 64'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      int f0, r0, n;
      logic [25:0] a;
      logic [15:0] c;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset = 1'b0;

      // abort in IDLE does nothing
      @(negedge clock); cfg_abort = 1'b1;
      @(negedge clock); cfg_abort = 1'b0;
      @(negedge clock);
      check("idle_abort_busy", 64'(busy), 64'd0);
      check("idle_abort_done", 64'(done), 64'd0);

      // five words from 0x1000, priv 1
      f0 = fwd_seen; r0 = req_acc;
      start_list(26'h1000, 16'd5, 1'b1);
      check("t1_busy", 64'(busy), 64'd1);
      wait_done("t1_done", 1000);
      check("t1_words", 64'(fwd_seen - f0), 64'd5);
      check("t1_left", 64'(exp_q.size()), 64'd0);
      check("t1_requests", 64'(req_acc - r0), 64'd1);
      @(negedge clock);
      check("t1_done_pulse", 64'(done), 64'd0);
      check("t1_busy_after", 64'(busy), 64'd0);

      // 40 words from 0: three bursts
      f0 = fwd_seen; r0 = req_acc;
      start_list(26'h0, 16'd40, 1'b0);
      wait_done("t2_done", 2000);
      check("t2_words", 64'(fwd_seen - f0), 64'd40);
      check("t2_requests", 64'(req_acc - r0), 64'd3);
      check("t2_req_left", 64'(req_q.size()), 64'd0);

      // no forwarding with only SLOT_MARGIN slots free
      slots_fixed = 10'd3;
      repeat (2) @(negedge clock);
      f0 = fwd_seen;
      start_list(26'h3000, 16'd20, 1'b1);
      quiet = 1;
      repeat (150) @(negedge clock);
      check("t3_held_words", 64'(fwd_seen - f0), 64'd0);
      check("t3_held_busy", 64'(busy), 64'd1);
      quiet = 0;
      slots_fixed = 10'd100;
      wait_done("t3_done", 1000);
      check("t3_words", 64'(fwd_seen - f0), 64'd20);
      check("t3_left", 64'(exp_q.size()), 64'd0);

      // abort mid-burst
      @(negedge clock);
      f0 = fwd_seen;
      start_list(26'h8000, 16'd40, 1'b1);
      n = 0;
      while (!((fwd_seen - f0) >= 3 && beats_left > 0 && beats_left < BURST) && n < 1000) begin
         @(negedge clock);
         n++;
      end
      check("t4_reached_data", 64'(n < 1000), 64'd1);
      cfg_abort = 1'b1;
      @(negedge clock);
      cfg_abort = 1'b0;
      quiet = 1;
      exp_q.delete();
      req_q.delete();
      n = 0;
      while (sdram_complete !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("t4_complete_seen", 64'(sdram_complete), 64'd1);
      check("t4_no_early_done", 64'(done), 64'd0);
      @(negedge clock);
      check("t4_done", 64'(done), 64'd1);
      check("t4_busy_low", 64'(busy), 64'd0);
      @(negedge clock);
      check("t4_done_pulse", 64'(done), 64'd0);
      check("t4_still_idle", 64'(busy), 64'd0);
      repeat (5) @(negedge clock);
      quiet = 0;

      // zero-length list
      r0 = req_acc;
      start_list(26'h4000, 16'd0, 1'b0);
      check("t5_done", 64'(done), 64'd1);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_request", 64'(sdram_request), 64'd0);
      @(negedge clock);
      check("t5_done_pulse", 64'(done), 64'd0);
      repeat (5) @(negedge clock);
      check("t5_no_requests", 64'(req_acc - r0), 64'd0);

      // reset while in DATA, then a fresh list
      start_list(26'h6000, 16'd40, 1'b0);
      n = 0;
      while (beats_left == 0 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check("t6_reached_data", 64'(n < 500), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("t6_reset");
      exp_q.delete();
      req_q.delete();
      reset = 1'b0;
      f0 = fwd_seen;
      start_list(26'h2004, 16'd7, 1'b1);
      wait_done("t6_done", 1000);
      check("t6_words", 64'(fwd_seen - f0), 64'd7);
      check("t6_left", 64'(exp_q.size()), 64'd0);

      // random lists with slot jitter, wrap-around bases and ignored restarts
      jitter = 1;
      for (int t = 0; t < 20; t++) begin
         a = 26'($urandom());
         if (t % 5 == 0) a = 26'h3FF_FFC0 + 26'($urandom_range(0, 63));
         c = 16'($urandom_range(1, 70));
         f0 = fwd_seen;
         start_list(a, c, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clock);
            cfg_address = 26'($urandom()); cfg_count = 16'd3; cfg_start = 1'b1;
            @(negedge clock);
            cfg_start = 1'b0;
         end
         wait_done("rand_done", 4000);
         check("rand_words", 64'(fwd_seen - f0), 64'(c));
         check("rand_left", 64'(exp_q.size()), 64'd0);
         check("rand_req_left", 64'(req_q.size()), 64'd0);
         @(negedge clock);
         check("rand_idle", 64'(busy), 64'd0);
      end
      jitter = 0;

      repeat (5) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
